// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - Thumb instruction fetch controller with optional halt detection (FETCH_HALT_DETECT_EN)
module fetch_ctrl #(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [15:0]       instr_count,
    output logic              halted
);

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_ADDR);

    // Thumb "B ." - a branch to itself, used by firmware as an idle loop
    localparam logic [15:0] LP_SELF_LOOP = 16'hE7FE;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_valid;
    logic [15:0]       r_count;

    logic w_xfer;
    logic w_load;
    logic w_halt_hit;

    // A transfer only happens while running; out_valid is always low elsewhere
    assign w_xfer = (r_state == S_RUN) && r_valid && out_ready;
    // The output slot can take a new word when it is empty or being drained
    assign w_load = !r_valid || out_ready;

`ifdef FETCH_HALT_DETECT_EN
    assign w_halt_hit = w_xfer && (r_instr == LP_SELF_LOOP);
    assign halted     = (r_state == S_HALT);
`else
    assign w_halt_hit = 1'b0;
    assign halted     = 1'b0;
`endif

    assign rom_addr    = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign out_valid   = r_valid;
    assign instr_count = r_count;

    // Transfer counter, wraps naturally at 16 bits; a branch does not cancel the transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 16'd0;
        end else if (w_xfer) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Fetch state machine: PC, output slot and run/halt state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RESET;
            r_pc       <= LP_RESET_PC;
            r_instr    <= 16'h0000;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (branch_valid) begin
                        r_pc    <= branch_target;
                        r_valid <= 1'b0;
                    end else if (w_halt_hit) begin
                        r_state <= S_HALT;
                        r_valid <= 1'b0;
                    end else if (w_load) begin
                        r_instr    <= rom_data[15:0];
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_pc       <= r_pc + 1'b1;
                    end
                end
                S_HALT: begin
                    if (branch_valid) begin
                        r_pc    <= branch_target;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RESET;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
